// File: rtl/ramb_asym_dp_sync.sv
// rtl/ramb_asym_dp_sync.sv - single-clock asymmetric true dual-port block RAM
// Optional collision detector/counter enabled by defining RAMB_ASYM_COLL_CHECK_EN.
module ramb_asym_dp_sync #(
    parameter int                               DATA_WIDTH_A = 8,
    parameter int                               ADDR_WIDTH_A = 11,
    parameter int                               RATIO        = 2,
    parameter string                            WRITE_MODE_A = "WRITE_FIRST",
    parameter string                            WRITE_MODE_B = "WRITE_FIRST",
    parameter int                               DO_REG_A     = 0,
    parameter int                               DO_REG_B     = 0,
    parameter logic [DATA_WIDTH_A-1:0]          SRVAL_A      = '0,
    parameter logic [DATA_WIDTH_A*RATIO-1:0]    SRVAL_B      = '0,
    localparam int                              LB           = $clog2(RATIO),
    localparam int                              ADDR_WIDTH_B = ADDR_WIDTH_A - LB
) (
    input  logic                                CLK,
    input  logic                                SSR,
    input  logic                                ENA,
    input  logic                                WEA,
    input  logic [ADDR_WIDTH_A-1:0]             ADDRA,
    input  logic [DATA_WIDTH_A-1:0]             DIA,
    output logic [DATA_WIDTH_A-1:0]             DOA,
    input  logic                                ENB,
    input  logic [RATIO-1:0]                    WEB,
    input  logic [ADDR_WIDTH_B-1:0]             ADDRB,
    input  logic [DATA_WIDTH_A*RATIO-1:0]       DIB,
    output logic [DATA_WIDTH_A*RATIO-1:0]       DOB,
    output logic                                COLL,
    output logic [7:0]                          COLL_CNT
);

    localparam int DW    = DATA_WIDTH_A;
    localparam int DWB   = DATA_WIDTH_A * RATIO;
    localparam int DEPTH = 1 << ADDR_WIDTH_A;
    localparam int LBW   = (LB > 0) ? LB : 1;

    localparam bit A_WF = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit A_RF = (WRITE_MODE_A == "READ_FIRST");
    localparam bit A_NC = (WRITE_MODE_A == "NO_CHANGE");
    localparam bit B_WF = (WRITE_MODE_B == "WRITE_FIRST");
    localparam bit B_RF = (WRITE_MODE_B == "READ_FIRST");
    localparam bit B_NC = (WRITE_MODE_B == "NO_CHANGE");

    if (!(RATIO == 1 || RATIO == 2 || RATIO == 4)) begin : g_bad_ratio
        $error("ramb_asym_dp_sync: RATIO must be 1, 2 or 4");
    end
    if (!(A_WF || A_RF || A_NC) || !(B_WF || B_RF || B_NC)) begin : g_bad_mode
        $error("ramb_asym_dp_sync: illegal write mode");
    end

    logic [DW-1:0]           mem [DEPTH];
    logic                    a_we;
    logic [RATIO-1:0]        b_we;
    logic [ADDR_WIDTH_A-1:0] b_addr [RATIO];
    logic [DW-1:0]           a_old;
    logic [DWB-1:0]          b_old;
    logic [DWB-1:0]          b_wf;
    logic [DW-1:0]           doa_lat;
    logic [DW-1:0]           doa_reg;
    logic [DWB-1:0]          dob_lat;
    logic [DWB-1:0]          dob_reg;

    always_comb begin
        a_we  = ENA & WEA;
        b_we  = ENB ? WEB : '0;
        a_old = mem[ADDRA];
        b_old = '0;
        b_wf  = '0;
        for (int i = 0; i < RATIO; i++) begin
            b_addr[i]           = ADDR_WIDTH_A'(int'(ADDRB) * RATIO + i);
            b_old[i*DW +: DW]   = mem[b_addr[i]];
            b_wf[i*DW +: DW]    = b_we[i] ? DIB[i*DW +: DW] : mem[b_addr[i]];
        end
    end

    // Port B is written after port A so it wins when both hit the same lane.
    // Reads always use the pre-edge array, so a reader on a colliding lane sees old data.
    always_ff @(posedge CLK) begin
        if (a_we) mem[ADDRA] <= DIA;
        for (int i = 0; i < RATIO; i++) begin
            if (b_we[i]) mem[b_addr[i]] <= DIB[i*DW +: DW];
        end
    end

    always_ff @(posedge CLK) begin
        if (SSR) begin
            doa_lat <= SRVAL_A;
            doa_reg <= SRVAL_A;
        end else begin
            doa_reg <= doa_lat;
            if (ENA) begin
                if (!WEA)      doa_lat <= a_old;
                else if (A_WF) doa_lat <= DIA;
                else if (A_RF) doa_lat <= a_old;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (SSR) begin
            dob_lat <= SRVAL_B;
            dob_reg <= SRVAL_B;
        end else begin
            dob_reg <= dob_lat;
            if (ENB) begin
                if (WEB == '0) dob_lat <= b_old;
                else if (B_WF) dob_lat <= b_wf;
                else if (B_RF) dob_lat <= b_old;
            end
        end
    end

    assign DOA = (DO_REG_A != 0) ? doa_reg : doa_lat;
    assign DOB = (DO_REG_B != 0) ? dob_reg : dob_lat;

`ifdef RAMB_ASYM_COLL_CHECK_EN
    logic [LBW-1:0] a_lane;
    logic           same_word;
    logic           coll_det;
    logic           coll_q;
    logic [7:0]     cnt_q;

    always_comb begin
        a_lane    = LBW'(int'(ADDRA) % RATIO);
        same_word = ((ADDRA >> LB) == ADDR_WIDTH_A'(ADDRB));
        coll_det  = ENA & ENB & same_word & (WEA | WEB[a_lane]);
    end

    always_ff @(posedge CLK) begin
        if (SSR) begin
            coll_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            coll_q <= coll_det;
            if (coll_det && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign COLL     = coll_q;
    assign COLL_CNT = cnt_q;
`else
    assign COLL     = 1'b0;
    assign COLL_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_ramb_asym_dp_sync.sv
// tb/tb_ramb_asym_dp_sync.sv - scoreboard bench for ramb_asym_dp_sync in three write-mode/pipeline variants
module tb_ramb_asym_dp_sync;

`ifdef RAMB_ASYM_COLL_CHECK_EN
    localparam int CC = 1;
`else
    localparam int CC = 0;
`endif

    logic        CLK = 1'b0;
    logic        SSR, ENA, WEA, ENB;
    logic [1:0]  WEB;
    logic [10:0] ADDRA;
    logic [9:0]  ADDRB;
    logic [7:0]  DIA;
    logic [15:0] DIB;
    logic [7:0]  doa0, doa1, doa2;
    logic [15:0] dob0, dob1, dob2;
    logic        coll0, coll1, coll2;
    logic [7:0]  cnt0, cnt1, cnt2;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
        string       nm;
    } exp_t;
    exp_t q[$];

    // u0: WF/WF no pipeline; u1: RF/NC with B pipeline; u2: NC/RF with A pipeline
    ramb_asym_dp_sync #(.SRVAL_A(8'h00), .SRVAL_B(16'h1234)) u0 (
        .CLK(CLK), .SSR(SSR), .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa0),
        .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob0), .COLL(coll0), .COLL_CNT(cnt0));

    ramb_asym_dp_sync #(.WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"), .DO_REG_B(1),
                        .SRVAL_A(8'h5C), .SRVAL_B(16'hFFFF)) u1 (
        .CLK(CLK), .SSR(SSR), .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa1),
        .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob1), .COLL(coll1), .COLL_CNT(cnt1));

    ramb_asym_dp_sync #(.WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"), .DO_REG_A(1),
                        .SRVAL_A(8'hE7), .SRVAL_B(16'h0000)) u2 (
        .CLK(CLK), .SSR(SSR), .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa2),
        .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob2), .COLL(coll2), .COLL_CNT(cnt2));

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] get(int s);
        case (s)
            0:  return {8'h00, doa0};
            1:  return {8'h00, doa1};
            2:  return {8'h00, doa2};
            3:  return dob0;
            4:  return dob1;
            5:  return dob2;
            6:  return {15'd0, coll0};
            7:  return {8'h00, cnt0};
            8:  return {15'd0, coll1};
            9:  return {8'h00, cnt1};
            10: return {15'd0, coll2};
            11: return {8'h00, cnt2};
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(negedge CLK) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                logic [15:0] act;
                act = get(q[i].sel);
                checks++;
                if (q[i].due < cyc || act !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h (cycle %0d)", q[i].nm, act, q[i].exp, cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic ex(int lat, int sel, logic [15:0] e, string nm);
        exp_t t;
        t.due = cyc + lat;
        t.sel = sel;
        t.exp = e;
        t.nm  = nm;
        q.push_back(t);
    endtask

    task automatic drv(logic ea, logic wa, logic [10:0] aa, logic [7:0] da,
                       logic eb, logic [1:0] wb, logic [9:0] ab, logic [15:0] db);
        ENA = ea; WEA = wa; ADDRA = aa; DIA = da;
        ENB = eb; WEB = wb; ADDRB = ab; DIB = db;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        SSR = 1'b1;
        drv(0, 0, 11'h000, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h0000, "rst_doa_u0");
        ex(1, 1, 16'h005C, "rst_doa_u1");
        ex(1, 2, 16'h00E7, "rst_doa_u2");
        ex(1, 3, 16'h1234, "rst_dob_u0");
        ex(1, 4, 16'hFFFF, "rst_dob_u1");
        ex(1, 5, 16'h0000, "rst_dob_u2");
        ex(1, 6, 16'h0000, "rst_coll");
        ex(1, 7, 16'h0000, "rst_cnt");
        ex(1, 8, 16'h0000, "rst_coll_u1");
        ex(1, 9, 16'h0000, "rst_cnt_u1");
        ex(1, 10, 16'h0000, "rst_coll_u2");
        ex(1, 11, 16'h0000, "rst_cnt_u2");
        step();
        step();
        SSR = 1'b0;

        // width mapping
        drv(1, 1, 11'h010, 8'h11, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h0011, "map_a_wr0_wf");
        ex(2, 2, 16'h00E7, "map_a_wr0_nc_hold");
        step();
        drv(1, 1, 11'h011, 8'h22, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h0022, "map_a_wr1_wf");
        step();
        drv(0, 0, 11'h000, 8'h00, 1, 2'b00, 10'h008, 16'h0000);
        ex(1, 3, 16'h2211, "map_b_rd_u0");
        ex(2, 4, 16'h2211, "map_b_rd_u1_pipe");
        ex(1, 5, 16'h2211, "map_b_rd_u2");
        step();
        drv(0, 0, 11'h000, 8'h00, 1, 2'b10, 10'h008, 16'hBEEF);
        ex(1, 3, 16'hBE11, "b_lane_wr_wf");
        ex(2, 4, 16'h2211, "b_lane_wr_nc");
        ex(1, 5, 16'h2211, "b_lane_wr_rf");
        step();
        drv(1, 0, 11'h011, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h00BE, "map_a_rd11_u0");
        ex(1, 1, 16'h00BE, "map_a_rd11_u1");
        ex(2, 2, 16'h00BE, "map_a_rd11_u2");
        step();
        drv(1, 0, 11'h010, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h0011, "map_a_rd10_u0");
        ex(1, 1, 16'h0011, "map_a_rd10_u1");
        ex(2, 2, 16'h0011, "map_a_rd10_u2");
        step();

        // write modes on port A
        drv(1, 1, 11'h020, 8'h5A, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h005A, "wm_setup_wf");
        ex(2, 2, 16'h0011, "wm_setup_nc");
        step();
        drv(1, 1, 11'h020, 8'hC3, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h00C3, "wm_write_first");
        ex(1, 1, 16'h005A, "wm_read_first");
        ex(2, 2, 16'h0011, "wm_no_change");
        step();
        drv(1, 0, 11'h020, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h00C3, "wm_rd_u0");
        ex(1, 1, 16'h00C3, "wm_rd_u1");
        ex(2, 2, 16'h00C3, "wm_rd_u2");
        step();

        // write-write collision
        drv(1, 1, 11'h031, 8'h77, 1, 2'b11, 10'h018, 16'hAA99);
        ex(1, 0, 16'h0077, "ww_doa_wf");
        ex(2, 2, 16'h00C3, "ww_doa_nc");
        ex(1, 3, 16'hAA99, "ww_dob_wf");
        ex(2, 4, 16'h2211, "ww_dob_nc");
        ex(1, 6, 16'(CC), "ww_coll");
        ex(1, 7, 16'(CC), "ww_cnt1");
        step();
        drv(1, 0, 11'h031, 8'h00, 1, 2'b00, 10'h018, 16'h0000);
        ex(1, 0, 16'h00AA, "ww_mem_u0");
        ex(1, 1, 16'h00AA, "ww_mem_u1");
        ex(2, 2, 16'h00AA, "ww_mem_u2");
        ex(1, 3, 16'hAA99, "ww_b_rd_u0");
        ex(2, 4, 16'hAA99, "ww_b_rd_u1");
        ex(1, 5, 16'hAA99, "ww_b_rd_u2");
        ex(1, 6, 16'h0000, "ww_coll_one_cycle");
        ex(1, 7, 16'(CC), "ww_cnt_hold");
        step();

        // read-write collision
        drv(1, 1, 11'h040, 8'h12, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h0012, "rw_setup");
        step();
        drv(1, 0, 11'h040, 8'h00, 1, 2'b01, 10'h020, 16'h0034);
        ex(1, 0, 16'h0012, "rw_doa_old_u0");
        ex(1, 1, 16'h0012, "rw_doa_old_u1");
        ex(2, 2, 16'h0012, "rw_doa_old_u2");
        ex(2, 4, 16'hAA99, "rw_dob_nc");
        ex(1, 6, 16'(CC), "rw_coll");
        ex(1, 7, 16'(CC * 2), "rw_cnt2");
        step();
        drv(1, 0, 11'h040, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 0, 16'h0034, "rw_new_u0");
        ex(2, 2, 16'h0034, "rw_new_u2");
        step();

        // counter saturation: 2 so far, +300 collisions
        for (int k = 0; k < 300; k++) begin
            drv(1, 1, 11'h031, 8'h77, 1, 2'b11, 10'h018, 16'hAA99);
            if (k == 251) ex(1, 7, 16'(CC * 254), "cnt_254");
            if (k == 299) ex(1, 7, 16'(CC * 255), "cnt_sat");
            step();
        end
        drv(0, 0, 11'h000, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 6, 16'h0000, "sat_coll_clear");
        ex(1, 7, 16'(CC * 255), "sat_cnt_hold");
        step();

        // B pipeline latency
        drv(0, 0, 11'h000, 8'h00, 1, 2'b00, 10'h008, 16'h0000);
        ex(1, 4, 16'hAA99, "pipe_not_yet");
        ex(2, 4, 16'hBE11, "pipe_lat2_a");
        step();
        drv(0, 0, 11'h000, 8'h00, 1, 2'b00, 10'h018, 16'h0000);
        ex(2, 4, 16'hAA99, "pipe_lat2_b");
        step();
        drv(0, 0, 11'h000, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        step();

        // SSR mid-burst, with a write in the SSR cycle
        drv(0, 0, 11'h000, 8'h00, 1, 2'b00, 10'h008, 16'h0000);
        ex(1, 3, 16'hBE11, "pre_ssr_rd");
        step();
        SSR = 1'b1;
        drv(1, 1, 11'h050, 8'h66, 0, 2'b00, 10'h000, 16'h0000);
        ex(1, 4, 16'hFFFF, "ssr_dob_c2");
        ex(2, 4, 16'hFFFF, "ssr_dob_c3");
        ex(1, 3, 16'h1234, "ssr_dob_u0");
        ex(1, 0, 16'h0000, "ssr_doa_u0");
        ex(1, 1, 16'h005C, "ssr_doa_u1");
        ex(1, 2, 16'h00E7, "ssr_doa_u2_s1");
        ex(2, 2, 16'h00E7, "ssr_doa_u2_s2");
        ex(1, 6, 16'h0000, "ssr_coll");
        ex(1, 7, 16'h0000, "ssr_cnt");
        step();
        SSR = 1'b0;
        drv(1, 0, 11'h050, 8'h00, 1, 2'b00, 10'h008, 16'h0000);
        ex(1, 0, 16'h0066, "ssr_write_kept");
        ex(1, 3, 16'hBE11, "post_ssr_rd_u0");
        ex(2, 4, 16'hBE11, "post_ssr_rd_u1");
        step();
        drv(0, 0, 11'h000, 8'h00, 0, 2'b00, 10'h000, 16'h0000);
        repeat (4) step();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d outstanding want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramb_asym_dp_sync.md
# ramb_asym_dp_sync

Parametrised single-clock true dual-port block RAM with asymmetric port widths. Port A is narrow, and port B is RATIO times wider, with per-lane write enables. The block adds selectable per-port write modes, an optional output pipeline register and deterministic cross-port collision resolution. It is the generic successor to the fixed-geometry S9/S18-class primitives and serves as the memory core for FIFOs and packet buffers that share one clock domain.

## Interface
- DATA_WIDTH_A, 8: port A word width in bits.
- ADDR_WIDTH_A, 11: port A address width; memory holds 2**ADDR_WIDTH_A A-words.
- RATIO, 2: port B width / port A width; legal values are 1, 2 and 4. Any other value fails elaboration via $error.
- WRITE_MODE_A, "WRITE_FIRST": one of "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
- WRITE_MODE_B, "WRITE_FIRST": same choices as WRITE_MODE_A.
- DO_REG_A, 0: 1 adds an output pipeline stage on port A.
- DO_REG_B, 0: 1 adds an output pipeline stage on port B.
- SRVAL_A, 0: DOA value after SSR; width DATA_WIDTH_A.
- SRVAL_B, 0: DOB value after SSR; width DATA_WIDTH_A*RATIO.
- Derived: LB = log2(RATIO); ADDR_WIDTH_B = ADDR_WIDTH_A-LB.
- CLK  in  1  single clock; all activity is on the rising edge.
- SSR  in  1  synchronous, active-high reset.
- ENA  in  1  port A enable.
- WEA  in  1  port A write enable; qualified by ENA.
- ADDRA  in  ADDR_WIDTH_A  port A address.
- DIA  in  DATA_WIDTH_A  port A write data.
- DOA  out  DATA_WIDTH_A  port A read data.
- ENB  in  1  port B enable.
- WEB  in  RATIO  per-lane write enable; qualified by ENB.
- ADDRB  in  ADDR_WIDTH_B  port B address.
- DIB  in  DATA_WIDTH_A*RATIO  port B write data.
- DOB  out  DATA_WIDTH_A*RATIO  port B read data.
- COLL  out  1  one-cycle collision pulse.
- COLL_CNT  out  8  saturating collision count.

## Operation
- **Addressing:** B lane i (bits [i*DW+:DW], where DW = DATA_WIDTH_A) maps to the A-word at address {ADDRB, i[LB-1:0]}. Lane 0 is the least significant lane.
- **Memory contents:** the array is not cleared by SSR. Initial simulation content is 0.
- **Port write:** a port writes when EN=1 and WEA=1 (port A) or WEB≠0 (port B). On port B only the enabled lanes are written. A cycle with EN=0 holds that port's output latch.
- **WRITE_FIRST:** on a write cycle the output shows the new data. For port B, written lanes show DIB and unwritten lanes show the stored data.
- **READ_FIRST:** on a write cycle the output shows the pre-write contents.
- **NO_CHANGE:** the output latch holds during write cycles.
- **Collision condition:** ENA=1, ENB=1, ADDRA[ADDR_WIDTH_A-1:LB] == ADDRB, and at least one port is writing the lane addressed by ADDRA[LB-1:0]. For RATIO=1 the address compare is a full compare.
- **Both ports write the same lane:** the memory stores DIB. DOA follows its own write mode using DIA, as if no collision occurred.
- **One port writes, the other reads:** the reading port returns the pre-write lane contents regardless of its own write mode.
- **Other lanes:** lanes not involved in the collision behave normally.
- **COLL / COLL_CNT:** COLL is registered and asserts in the cycle after a colliding edge. COLL_CNT increments on each COLL pulse and saturates at 255.
- **SSR:** DOA←SRVAL_A, DOB←SRVAL_B in both pipeline stages, COLL←0, COLL_CNT←0. SSR has priority over EN, but writes requested in an SSR cycle still update memory.

## Timing
- Read latency is 1 cycle for DO_REG=0 and 2 cycles for DO_REG=1, measured from the sampling edge.
- The DO_REG stage loads the latch output every cycle; it is not gated by EN.
- A write becomes visible to reads on either port at the following edge.
- Reset values: DOA=SRVAL_A, DOB=SRVAL_B, COLL=0, COLL_CNT=0.
- If SSR is asserted mid-burst, the first edge with SSR=0 accepts a new access. That data appears after the normal latency; earlier in-flight reads are discarded.
- Back-to-back accesses on every cycle are supported on both ports. There is no stall or handshake.

## Configuration
- RAMB_ASYM_COLL_CHECK_EN
  - **Defined:** the collision detector, COLL and COLL_CNT are implemented as described above.
  - **Undefined:** COLL and COLL_CNT are tied to 0 and the comparison logic is removed. Data resolution is unchanged: port B still wins write-write conflicts and readers still get old data.

## Test plan
All scenarios use DATA_WIDTH_A=8, ADDR_WIDTH_A=11, RATIO=2.
- **Width mapping:** A writes 0x11@0x010 and 0x22@0x011, then B reads ADDRB=0x008 → DOB=0x2211 one cycle later. B then writes 0xBEEF, WEB=2'b10, @0x008 → A reads 0x011=0xBE and 0x010=0x11.
- **Write modes:** memory@0x020 holds 0x5A; A writes 0xC3 there → DOA=0xC3 (WRITE_FIRST), 0x5A (READ_FIRST) or the prior DOA held (NO_CHANGE).
- **Write-write collision:** A writes 0x77@0x031 while B writes 0xAA99, WEB=2'b11, @0x018 → memory@0x031=0xAA; COLL=1 for one cycle; COLL_CNT=1. Repeat 300 times → COLL_CNT=255.
- **Read-write collision:** memory@0x040=0x12; A reads 0x040 while B writes 0x0034, WEB=2'b01, @0x020 → DOA=0x12, COLL=1; next A read → 0x34.
- **Pipeline and reset:** DO_REG_B=1, SRVAL_B=0xFFFF; a B read at cycle 0 → DOB valid at cycle 2; SSR at cycle 1 → DOB=0xFFFF at cycles 2–3, COLL_CNT=0.
- **Macro off:** repeat the write-write collision scenario without RAMB_ASYM_COLL_CHECK_EN → memory@0x031=0xAA, COLL=0, COLL_CNT=0.
